// File: rtl/pack_scale_unit.sv
// Sequential scale-and-add unit: ans = P*K + A via an iterative shift-add multiplier.
// Mode selects operand roles; start/busy/done handshake with fixed KW+1 cycle latency.
module pack_scale_unit #(
  parameter int W       = 3,
  parameter int KW      = 5,
  parameter int OW      = 8,
  parameter int SCALE_A = 8,
  parameter int SCALE_B = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  output logic          busy,
  output logic          done,
  output logic [OW-1:0] ans,
  output logic          ovf
);

  localparam int AW = W + KW + 1;
  localparam int CW = (KW > 1) ? $clog2(KW) : 1;

  typedef enum logic [1:0] {IDLE, MUL, ADD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   p_q, p_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    a_q, a_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [OW-1:0]   ans_q, ans_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic [AW-1:0]   sum;

  // Any bit at or above OW means the full result did not fit in ans.
  function automatic logic over_range(input logic [AW-1:0] v);
    return (v >> OW) != '0;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    k_d     = k_q;
    a_d     = a_q;
    acc_d   = acc_q;
    ans_d   = ans_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    sum     = acc_q + AW'(a_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MUL;
          cnt_d   = '0;
          acc_d   = '0;
          case (mode)
            2'd0: begin p_d = AW'(x); k_d = KW'(SCALE_A); a_d = y;  end
            2'd1: begin p_d = AW'(y); k_d = KW'(SCALE_B); a_d = x;  end
            2'd2: begin p_d = AW'(x); k_d = KW'(y);       a_d = '0; end
            default: begin p_d = AW'(x); k_d = KW'(1);    a_d = y;  end
          endcase
        end
      end
      // No early exit on k==0: latency stays fixed at KW multiply cycles.
      MUL: begin
        if (k_q[0]) acc_d = acc_q + p_q;
        p_d   = p_q << 1;
        k_d   = k_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(KW - 1)) state_d = ADD;
      end
      ADD: begin
        ans_d   = sum[OW-1:0];
        ovf_d   = over_range(sum);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ans_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ans_q   <= ans_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Datapath operands are always reloaded on start, so they carry no reset.
  always_ff @(posedge clk) begin
    p_q   <= p_d;
    k_q   <= k_d;
    a_q   <= a_d;
    acc_q <= acc_d;
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign ans  = ans_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_pack_scale_unit.sv
// Randomized and directed bench for pack_scale_unit, default build plus an OW=6 build
// driven from the same inputs and checked against an arithmetic reference model.
module tb_pack_scale_unit;

  localparam int KW = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] x = 3'd0;
  logic [2:0] y = 3'd0;

  logic       busy, done, ovf;
  logic [7:0] ans;
  logic       busy6, done6, ovf6;
  logic [5:0] ans6;

  int checks = 0;
  int errors = 0;

  pack_scale_unit dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .x(x), .y(y),
    .busy(busy), .done(done), .ans(ans), .ovf(ovf)
  );

  pack_scale_unit #(.OW(6)) dut6 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .x(x), .y(y),
    .busy(busy6), .done(done6), .ans(ans6), .ovf(ovf6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_full(input int m, input int xv, input int yv);
    case (m)
      0:       return xv * 8 + yv;
      1:       return xv + yv * 16;
      2:       return xv * yv;
      default: return xv + yv;
    endcase
  endfunction

  // Runs one operation; if immediate, start is raised in the current cycle
  // (used for back-to-back issue from the done cycle). Ends 1ns after the done edge.
  task automatic do_op(input int m, input int xv, input int yv,
                       input bit immediate, input bit scramble);
    int cyc = 0;
    int busy_cnt = 0;
    bit got_done = 0;
    int full;
    if (!immediate) begin
      @(posedge clk); #1;
    end
    start = 1'b1; mode = 2'(m); x = 3'(xv); y = 3'(yv);
    full = ref_full(m, xv, yv);
    @(posedge clk); #1;
    start = 1'b0;
    if (busy) busy_cnt++;
    while (!got_done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (scramble) begin
        start = (cyc == 2 || cyc == 4);
        mode  = 2'($urandom_range(0, 3));
        x     = 3'($urandom);
        y     = 3'($urandom);
      end
      if (done) got_done = 1;
      else if (busy) busy_cnt++;
    end
    start = 1'b0;
    chk("done_seen", int'(got_done), 1);
    chk("latency", cyc, KW + 1);
    chk("busy_cycles", busy_cnt, KW + 1);
    chk("ans", int'(ans), full % 256);
    chk("ovf", int'(ovf), int'(full >= 256));
    chk("ans_ow6", int'(ans6), full % 64);
    chk("ovf_ow6", int'(ovf6), int'(full >= 64));
  endtask

  task automatic quiet(input int n, input int exp_ans);
    int extra = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done || done6) extra++;
    end
    chk("no_extra_done", extra, 0);
    chk("ans_held", int'(ans), exp_ans);
  endtask

  initial begin
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ans", int'(ans), 0);
    chk("rst_ovf", int'(ovf | ovf6), 0);
    @(negedge clk); rst = 1'b0;

    do_op(0, 7, 5, 0, 0);
    do_op(1, 3, 7, 0, 0);
    do_op(2, 6, 7, 0, 0);
    do_op(3, 7, 7, 0, 0);
    do_op(1, 1, 7, 0, 0);
    do_op(3, 1, 1, 0, 0);

    do_op(0, 5, 6, 0, 1);
    quiet(12, 46);

    do_op(2, 7, 7, 0, 0);
    do_op(0, 1, 1, 1, 0);

    for (int i = 0; i < 12; i++)
      do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), 0, 0);

    do_op(1, 7, 7, 0, 0);
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd0; x = 3'd6; y = 3'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_busy", int'(busy | busy6), 0);
    chk("async_done", int'(done | done6), 0);
    chk("async_ans", int'(ans), 0);
    chk("async_ans6", int'(ans6), 0);
    chk("async_ovf", int'(ovf | ovf6), 0);
    @(negedge clk); rst = 1'b0;
    quiet(12, 0);
    do_op(0, 2, 3, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
